// File: rtl/ir_queue.sv
// ============================================================================
// ir_queue : DEPTH-entry instruction buffer with MIPS field decode and flush
// Revision : 1.0
// ============================================================================
`default_nettype none

module ir_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic [25:0]      imm26,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             w_push, w_pop;

  // Handshake readiness depends on registered occupancy only.
  assign in_ready  = (count_q != C_FULL);
  assign out_valid = (count_q != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; an empty queue masks it on the output.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign instr  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];
  assign imm26  = instr[25:0];
  assign count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_ir_queue.sv
// ============================================================================
// tb_ir_queue : directed self-checking bench for ir_queue (DEPTH=4)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ir_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] instr;
  logic [5:0]       opcode;
  logic [4:0]       rs, rt, rd, shamt;
  logic [5:0]       funct;
  logic [15:0]      imm16;
  logic [25:0]      imm26;
  logic [CW-1:0]    count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .imm16     (imm16),
    .imm26     (imm26),
    .count     (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] seq [8];
  logic [31:0] fill [5];
  logic [2:0]  exp_cnt [5];
  logic        exp_rdy [5];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset/idle state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_funct", 32'(funct), 32'd0);

    // Pop request while empty is ignored
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("empty_pop_count", 32'(count), 32'd0);

    // add $8,$9,$10 decode
    push_one(32'h012A4020);
    chk("add_out_valid", 32'(out_valid), 32'd1);
    chk("add_opcode", 32'(opcode), 32'd0);
    chk("add_rs", 32'(rs), 32'd9);
    chk("add_rt", 32'(rt), 32'd10);
    chk("add_rd", 32'(rd), 32'd8);
    chk("add_shamt", 32'(shamt), 32'd0);
    chk("add_funct", 32'(funct), 32'h20);
    chk("add_imm16", 32'(imm16), 32'h4020);
    chk("add_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("add_popped_count", 32'(count), 32'd0);
    chk("add_popped_instr", instr, 32'h0);

    // Fill to full; pointers start at 1 so the writes wrap 3->0
    fill[0] = 32'hA000_000A; fill[1] = 32'hB000_000B; fill[2] = 32'hC000_000C;
    fill[3] = 32'hD000_000D; fill[4] = 32'hE000_000E;
    for (int i = 0; i < 4; i++) push_one(fill[i]);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);

    in_valid = 1'b1; in_data = fill[4];
    step();
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_head", instr, fill[0]);

    // Drain while E is held; E enters on the in_ready rise (second cycle)
    exp_cnt[0] = 3'd3; exp_cnt[1] = 3'd3; exp_cnt[2] = 3'd2; exp_cnt[3] = 3'd1; exp_cnt[4] = 3'd0;
    exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b1; exp_rdy[3] = 1'b1; exp_rdy[4] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain_head%0d", i), instr, fill[i]);
      chk($sformatf("drain_in_ready%0d", i), 32'(in_ready), 32'(exp_rdy[i]));
      step();
      if (i == 1) in_valid = 1'b0;
      chk($sformatf("drain_count%0d", i), 32'(count), 32'(exp_cnt[i]));
    end
    out_ready = 1'b0;
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Steady-state concurrent push/pop at count=2
    for (int i = 0; i < 8; i++) seq[i] = 32'h1000_0000 + 32'(i * 32'h0101);
    push_one(seq[0]);
    push_one(seq[1]);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = seq[i + 2];
      chk($sformatf("pp_head%0d", i), instr, seq[i]);
      step();
      chk($sformatf("pp_count%0d", i), 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    for (int i = 6; i < 8; i++) begin
      chk($sformatf("pp_tail%0d", i), instr, seq[i]);
      step();
    end
    out_ready = 1'b0;
    chk("pp_empty", 32'(count), 32'd0);

    // Flush beats same-cycle push and pop
    push_one(32'h1111_1111);
    push_one(32'h2222_2222);
    push_one(32'h3333_3333);
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_instr", instr, 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("flush_no_ghost", 32'(out_valid), 32'd0);

    // Reset overrides push
    push_one(32'h4444_4444);
    push_one(32'h5555_5555);
    push_one(32'h6666_6666);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h7777_7777;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    push_one(32'h0800_0010);
    chk("j_opcode", 32'(opcode), 32'd2);
    chk("j_imm26", 32'(imm26), 32'h0000010);
    chk("j_count", 32'(count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised instruction register successor: a DEPTH-entry instruction buffer between instruction memory and the control unit.
- Fetch pushes words in with a valid/ready handshake. The control unit consumes the head entry with a valid/ready handshake.
- Head entry is decoded into MIPS fields (opcode, rs, rt, rd, shamt, funct, imm16, imm26).
- Adds a flush for branches/jumps, and an occupancy count.

Parameters:
- WIDTH, 32, instruction word width; must be 32 for field decode; other values are reserved.
- DEPTH, 4, number of buffer entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, width of the count output (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  fetch presents in_data
- in_ready  out  1  buffer can accept a word this cycle
- in_data  in  WIDTH  instruction word from memory
- flush  in  1  discard all buffered entries (taken branch/jump)
- out_valid  out  1  head entry valid
- out_ready  in  1  control unit consumes head this cycle (IRWr equivalent)
- instr  out  WIDTH  head instruction word
- opcode  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- shamt  out  5  instr[10:6]
- funct  out  6  instr[5:0]
- imm16  out  16  instr[15:0]
- imm26  out  26  instr[25:0]
- count  out  CW  number of valid entries, 0..DEPTH

Behaviour:
- Circular buffer with wr_ptr and rd_ptr (log2 DEPTH bits, wrap modulo DEPTH) and a registered count.
- Reset (rst_n low at a clk edge): wr_ptr=rd_ptr=0, count=0. Storage contents need no reset. Reset overrides flush, push and pop in the same cycle.
- in_ready = (count != DEPTH), combinational from registered count only. There is no out_ready->in_ready path.
- out_valid = (count != 0).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Push: mem[wr_ptr] <= in_data; wr_ptr increments.
- Pop: rd_ptr increments.
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged and is legal at any occupancy below full. When full, only a pop occurs (in_ready=0).
- Latency: a word pushed at edge N is visible on instr/out_valid after edge N; first consumable cycle is N+1. No combinational in_data->instr bypass.
- instr = mem[rd_ptr] when out_valid, else 0. All field outputs are pure slices of instr, so every field reads 0 when empty (opcode 0 = R-type nop-equivalent).
- Consuming the last entry while a push occurs the same edge: the new word becomes head on the next cycle; count stays 1.
- Flush (rst_n high): wr_ptr=rd_ptr=0 and count=0 at the edge.
  - Any same-cycle push is dropped: flush beats push.
  - Any same-cycle pop is dropped.
  - After a flush edge: out_valid=0, in_ready=1.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Ordering must remain FIFO across wrap.
- Upstream may hold in_valid with a stable in_data while in_ready=0. The word is accepted exactly once, when in_ready rises.
- out_ready with out_valid=0 is ignored: no pointer change, no underflow.
- in_valid with in_ready=0 is ignored: no overwrite, no overflow.

Test Plan:
- Reset, then idle -> count=0, out_valid=0, in_ready=1, instr=0, opcode=0, funct=0.
- Push 0x012A4020 (add $8,$9,$10), out_ready=0 -> next cycle out_valid=1, opcode=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20, imm16=0x4020, count=1.
- Push 4 words A,B,C,D with out_ready=0 (DEPTH=4):
  - count=4, in_ready=0.
  - Fifth word E held with in_valid=1 is not accepted.
  - Then out_ready=1 for 5 cycles -> A,B,C,D pop in order; E is accepted on the in_ready rise and pops after D.
  - Wrap across index 3->0 is correct.
- Count=2 with simultaneous push and pop for 6 cycles -> count stays 2; output order matches input order.
- Count=3 with flush=1, in_valid=1, out_ready=1 on the same edge -> next cycle count=0, out_valid=0, instr=0; the pushed word never appears.
- Count=3, assert rst_n=0 for one edge while flush=0 and in_valid=1 -> count=0, out_valid=0. A subsequent push 0x08000010 (j) yields opcode=2, imm26=0x0000010.
